// File: rtl/fp_pkg.sv
// Shared FPU constants and pipeline payload types for the round/pack stage.
package fp_pkg;

   localparam int unsigned DataSize     = 32;
   localparam int unsigned FractionSize = 23;
   localparam int unsigned MantissaSize = FractionSize + 1;
   localparam int unsigned ExponentSize = 8;

   localparam logic [ExponentSize-1:0] EXP_INF = 8'hFF;
   localparam logic [DataSize-1:0]     POS_INF = 32'h7F80_0000;
   localparam logic [DataSize-1:0]     NEG_INF = 32'hFF80_0000;
   localparam logic [DataSize-1:0]     ZERO    = 32'h0000_0000;

   localparam int unsigned NumFlags = 2;
   localparam int unsigned FLAG_OVF = 0;
   localparam int unsigned FLAG_UNF = 1;

   // Sum keeps one extra MSB so a rounding carry-out can be renormalised in S2.
   typedef struct packed {
      logic                    sign;
      logic [MantissaSize:0]   sum;
      logic [ExponentSize:0]   exp9;
      logic                    carry;
      logic                    zero;
   } s1_t;

endpackage

// File: rtl/fp_pack_exception.sv
// Combinational S2 logic: round-carry renormalisation, overflow/underflow classification, packing.
import fp_pkg::*;

module fp_pack_exception (
   input  s1_t                 s1_i,
   output logic [DataSize-1:0] result_o,
   output logic                overflow_o,
   output logic                underflow_o
);

   logic [ExponentSize:0]   exp_adj;
   logic [FractionSize-1:0] frac;
   logic                    ovf;
   logic                    unf;

   always_comb begin
      if (s1_i.sum[MantissaSize]) begin
         frac    = s1_i.sum[MantissaSize-1:1];
         exp_adj = s1_i.exp9 + (ExponentSize+1)'(1);
      end else begin
         frac    = s1_i.sum[FractionSize-1:0];
         exp_adj = s1_i.exp9;
      end

      ovf = s1_i.carry | (exp_adj >= {1'b0, EXP_INF});
      unf = (exp_adj == '0);

      result_o    = {s1_i.sign, exp_adj[ExponentSize-1:0], frac};
      overflow_o  = 1'b0;
      underflow_o = 1'b0;

      // Zero wins over overflow, which wins over underflow.
      if (s1_i.zero) begin
         result_o = {s1_i.sign, ZERO[DataSize-2:0]};
      end else if (ovf) begin
         result_o   = s1_i.sign ? NEG_INF : POS_INF;
         overflow_o = 1'b1;
      end else if (unf) begin
         result_o    = {s1_i.sign, ZERO[DataSize-2:0]};
         underflow_o = 1'b1;
      end
   end

endmodule

// File: rtl/fp_round_pack_stage.sv
// FPU stage 5: two registered sub-stages (round-add, then renormalise/pack) with valid/ready and sticky flags.
import fp_pkg::*;

module fp_round_pack_stage (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    InValid,
   output logic                    InReady,
   input  logic                    Sign,
   input  logic [MantissaSize-1:0] TobeRounded,
   input  logic                    Round,
   input  logic [ExponentSize-1:0] NewExponent1,
   input  logic                    EffExponentAdderCarry1,
   output logic                    OutValid,
   input  logic                    OutReady,
   output logic [DataSize-1:0]     Result,
   output logic                    ResOverflow,
   output logic                    ResUnderflow,
   input  logic                    ClearFlags,
   output logic                    FlagOverflow,
   output logic                    FlagUnderflow
);

   logic                advance;
   logic                s1_valid_q, s1_valid_d;
   s1_t                 s1_q, s1_d;
   logic                out_valid_q, out_valid_d;
   logic [DataSize-1:0] result_q, result_d;
   logic [NumFlags-1:0] res_flags_q, res_flags_d;
   logic [NumFlags-1:0] flags_q, flags_d;
   logic [DataSize-1:0] pk_result;
   logic                pk_ovf;
   logic                pk_unf;

   fp_pack_exception u_pack (
      .s1_i        (s1_q),
      .result_o    (pk_result),
      .overflow_o  (pk_ovf),
      .underflow_o (pk_unf)
   );

   always_comb begin
      // The whole pipe moves as one unit whenever the output slot is free or draining.
      advance     = ~out_valid_q | OutReady;
      s1_valid_d  = s1_valid_q;
      s1_d        = s1_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      res_flags_d = res_flags_q;

      if (advance) begin
         s1_valid_d  = InValid;
         s1_d.sign   = Sign;
         s1_d.sum    = {1'b0, TobeRounded} + (MantissaSize+1)'(Round);
         s1_d.exp9   = {1'b0, NewExponent1};
         s1_d.carry  = EffExponentAdderCarry1;
         s1_d.zero   = (TobeRounded == '0);

         out_valid_d           = s1_valid_q;
         result_d              = pk_result;
         res_flags_d           = '0;
         res_flags_d[FLAG_OVF] = s1_valid_q & pk_ovf;
         res_flags_d[FLAG_UNF] = s1_valid_q & pk_unf;
      end

      // An event leaving this cycle is ORed in after the clear so it is never lost.
      flags_d = (ClearFlags ? '0 : flags_q) | ((out_valid_q & OutReady) ? res_flags_q : '0);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         res_flags_q <= '0;
         flags_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_q        <= s1_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         res_flags_q <= res_flags_d;
         flags_q     <= flags_d;
      end
   end

   assign InReady       = advance;
   assign OutValid      = out_valid_q;
   assign Result        = result_q;
   assign ResOverflow   = res_flags_q[FLAG_OVF];
   assign ResUnderflow  = res_flags_q[FLAG_UNF];
   assign FlagOverflow  = flags_q[FLAG_OVF];
   assign FlagUnderflow = flags_q[FLAG_UNF];

endmodule
